// File: rtl/instruction_fetch_responder.sv
// Fixed-latency, single-outstanding instruction fetch responder over a loadable
// instruction array, with flush, alignment and range checking.
module instruction_fetch_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clock,
    input  logic                           resetMachine,
    input  logic                           requestValid_Fetch,
    input  logic [31:0]                    requestAddress_Fetch,
    input  logic                           flushRequest_Fetch,
    output logic                           requestReady_Memory,
    output logic                           responseValid_Memory,
    output logic [31:0]                    responseInstruction_Memory,
    output logic [31:0]                    responseAddress_Memory,
    output logic                           responseError_Memory,
    input  logic                           loadEnable,
    input  logic [$clog2(DEPTH_WORDS)-1:0] loadAddress,
    input  logic [31:0]                    loadData
);
    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [31:0] addr;
    logic [31:0] addr_next;
    logic [31:0] array [DEPTH_WORDS];
    logic        accept;
    logic        capture;
    logic [31:0] capture_addr;
    logic        capture_error;
    logic [31:0] capture_data;

    function automatic logic address_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH_WORDS));
    endfunction

    // Ready/accept decode, next-state logic and selection of the address to capture.
    always_comb begin
        state_next           = state;
        count_next           = count;
        addr_next            = addr;
        capture              = 1'b0;
        capture_addr         = addr;
        requestReady_Memory  = ((state == IDLE) || (state == RESPOND)) &&
                               !loadEnable && !flushRequest_Fetch;
        responseValid_Memory = (state == RESPOND) && !flushRequest_Fetch;
        accept               = requestValid_Fetch && requestReady_Memory;
        case (state)
            IDLE, RESPOND: begin
                if (accept) begin
                    addr_next  = requestAddress_Fetch;
                    count_next = LOAD_COUNT;
                    // Single-cycle latency skips WAIT and captures straight from the request.
                    if (LATENCY == 1) begin
                        state_next   = RESPOND;
                        capture      = 1'b1;
                        capture_addr = requestAddress_Fetch;
                    end else begin
                        state_next = WAIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (flushRequest_Fetch) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count == 4'd1) begin
                    state_next = RESPOND;
                    count_next = 4'd0;
                    capture    = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    assign capture_error = address_error(capture_addr);
    assign capture_data  = capture_error ? 32'h0000_0000 : array[capture_addr[AW+1:2]];

    // State register, latency counter, latched address and registered response fields.
    always_ff @(posedge clock) begin
        if (resetMachine) begin
            state                      <= IDLE;
            count                      <= 4'd0;
            addr                       <= 32'h0000_0000;
            responseInstruction_Memory <= 32'h0000_0000;
            responseAddress_Memory     <= 32'h0000_0000;
            responseError_Memory       <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            addr  <= addr_next;
            if (capture) begin
                responseInstruction_Memory <= capture_data;
                responseAddress_Memory     <= capture_addr;
                responseError_Memory       <= capture_error;
            end
        end
    end

    // Instruction array: written only while idle, contents survive reset.
    always_ff @(posedge clock) begin
        if (!resetMachine && loadEnable && (state == IDLE)) begin
            array[loadAddress] <= loadData;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: three instances (LATENCY 1/2/3) share
// stimulus and are checked each cycle against a due-time scoreboard model.
module tb_instruction_fetch_responder;
    localparam int DEPTH = 16;
    localparam int NDUT  = 3;

    logic        clock = 1'b0;
    logic        resetMachine = 1'b1;
    logic        requestValid_Fetch = 1'b0;
    logic [31:0] requestAddress_Fetch = 32'h0;
    logic        flushRequest_Fetch = 1'b0;
    logic        loadEnable = 1'b0;
    logic [3:0]  loadAddress = 4'h0;
    logic [31:0] loadData = 32'h0;

    logic        ready [NDUT];
    logic        valid [NDUT];
    logic [31:0] inst  [NDUT];
    logic [31:0] raddr [NDUT];
    logic        err   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        instruction_fetch_responder #(.LATENCY(g + 1), .DEPTH_WORDS(DEPTH)) u_dut (
            .clock                      (clock),
            .resetMachine               (resetMachine),
            .requestValid_Fetch         (requestValid_Fetch),
            .requestAddress_Fetch       (requestAddress_Fetch),
            .flushRequest_Fetch         (flushRequest_Fetch),
            .requestReady_Memory        (ready[g]),
            .responseValid_Memory       (valid[g]),
            .responseInstruction_Memory (inst[g]),
            .responseAddress_Memory     (raddr[g]),
            .responseError_Memory       (err[g]),
            .loadEnable                 (loadEnable),
            .loadAddress                (loadAddress),
            .loadData                   (loadData)
        );
    end

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding request per instance, due at a fixed cycle.
    int          cyc = 0;
    bit          pend   [NDUT];
    int          due    [NDUT];
    logic [31:0] paddr  [NDUT];
    logic [31:0] m_inst [NDUT];
    logic [31:0] m_addr [NDUT];
    bit          m_err  [NDUT];
    logic [31:0] mem    [NDUT][DEPTH];

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] a;
        bit          fl;
        bit          ld;
        logic [3:0]  la;
        logic [31:0] ldd;
        bit          e_rdy;
        bit          e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        bit          e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            bit resp_now;
            bit rdy;
            resp_now = pend[k] && (due[k] == cyc);
            rdy      = (!pend[k] || resp_now) && !loadEnable && !flushRequest_Fetch;
            check($sformatf("model L%0d ready", k + 1), ready[k], rdy);
            check($sformatf("model L%0d valid", k + 1), valid[k], resp_now && !flushRequest_Fetch);
            check($sformatf("model L%0d inst", k + 1), inst[k], m_inst[k]);
            check($sformatf("model L%0d addr", k + 1), raddr[k], m_addr[k]);
            check($sformatf("model L%0d err", k + 1), err[k], m_err[k]);
            if (resetMachine) begin
                pend[k]   = 1'b0;
                m_inst[k] = 32'h0;
                m_addr[k] = 32'h0;
                m_err[k]  = 1'b0;
            end else begin
                if (!pend[k] && loadEnable) mem[k][loadAddress] = loadData;
                if (pend[k] && (resp_now || flushRequest_Fetch)) pend[k] = 1'b0;
                if (requestValid_Fetch && rdy) begin
                    pend[k]  = 1'b1;
                    due[k]   = cyc + k + 1;
                    paddr[k] = requestAddress_Fetch;
                end
                if (pend[k] && (due[k] == cyc + 1)) begin
                    m_addr[k] = paddr[k];
                    m_err[k]  = (paddr[k] % 4 != 0) || (paddr[k] / 4 >= DEPTH);
                    m_inst[k] = m_err[k] ? 32'h0 : mem[k][paddr[k] / 4];
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input bit rst, input bit v, input logic [31:0] a, input bit fl,
                        input bit ld, input logic [3:0] la, input logic [31:0] ldd);
        @(posedge clock);
        #1;
        resetMachine         = rst;
        requestValid_Fetch   = v;
        requestAddress_Fetch = a;
        flushRequest_Fetch   = fl;
        loadEnable           = ld;
        loadAddress          = la;
        loadData             = ldd;
        @(negedge clock);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            pend[k] = 1'b0; due[k] = 0; paddr[k] = 32'h0;
            m_inst[k] = 32'h0; m_addr[k] = 32'h0; m_err[k] = 1'b0;
        end
        // Directed vectors; expectations are for the LATENCY=2 instance.
        tbl[0]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 4'd3, 32'h2002_0005, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h06, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h06, 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h06, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h06, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h06, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h40, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h2002_0005, 32'h0C, 1'b0};

        repeat (2) @(posedge clock);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(1);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset L%0d ready", k + 1), ready[k], 32'h1);
            check($sformatf("reset L%0d valid", k + 1), valid[k], 32'h0);
            check($sformatf("reset L%0d inst", k + 1), inst[k], 32'h0);
        end

        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'(i), 32'hC0DE_0000 + 32'(i));

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].fl, tbl[i].ld, tbl[i].la, tbl[i].ldd);
            check($sformatf("tbl%0d ready", i), ready[1], tbl[i].e_rdy);
            check($sformatf("tbl%0d valid", i), valid[1], tbl[i].e_vld);
            check($sformatf("tbl%0d inst", i), inst[1], tbl[i].e_inst);
            check($sformatf("tbl%0d addr", i), raddr[1], tbl[i].e_addr);
            check($sformatf("tbl%0d err", i), err[1], tbl[i].e_err);
        end

        // LATENCY=1 back-to-back requests give one pulse per cycle.
        idle(3);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        check("b2b c0 ready", ready[0], 32'h1);
        check("b2b c0 valid", valid[0], 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, i < 3, 32'(4 * i), 1'b0, 1'b0, 4'h0, 32'h0);
            check($sformatf("b2b c%0d ready", i), ready[0], 32'h1);
            check($sformatf("b2b c%0d valid", i), valid[0], 32'h1);
            check($sformatf("b2b c%0d addr", i), raddr[0], 32'(4 * (i - 1)));
            check($sformatf("b2b c%0d inst", i), inst[0], 32'hC0DE_0000 + 32'(i - 1));
        end
        idle(1);
        check("b2b end valid", valid[0], 32'h0);

        // LATENCY=3 flush in WAIT abandons the request.
        idle(4);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0);
        check("flush accept ready", ready[2], 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        idle(1);
        check("flush idle ready", ready[2], 32'h1);
        idle(1);
        check("flush no response", valid[2], 32'h0);

        // LATENCY=3 reset after acceptance; array survives.
        idle(4);
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(1);
        check("rst ready", ready[2], 32'h1);
        check("rst inst", inst[2], 32'h0);
        check("rst addr", raddr[2], 32'h0);
        check("rst err", err[2], 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check($sformatf("rst no response %0d", i), valid[2], 32'h0);
        end
        step(1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(3);
        check("survive valid", valid[2], 32'h1);
        check("survive inst", inst[2], 32'h2002_0005);
        check("survive addr", raddr[2], 32'h0C);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
            else               a = $urandom;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, a,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 12,
                 4'($urandom_range(0, DEPTH - 1)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_responder.md
INSTRUCTION_FETCH_RESPONDER -- requirements
Module: instruction_fetch_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 256, meaning instruction array size in 32-bit words; power of two.
REQ-003 clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 resetMachine  input  1  meaning reset; synchronous, active-high.
REQ-005 requestValid_Fetch  input  1  meaning a fetch request is present.
REQ-006 requestAddress_Fetch  input  32  meaning the byte address of the requested instruction.
REQ-007 flushRequest_Fetch  input  1  meaning abandon in-flight work and suppress the current response.
REQ-008 requestReady_Memory  output  1  meaning the block accepts a request this cycle.
REQ-009 responseValid_Memory  output  1  meaning a one-cycle response pulse.
REQ-010 responseInstruction_Memory  output  32  meaning the returned instruction word.
REQ-011 responseAddress_Memory  output  32  meaning the byte address that the response belongs to.
REQ-012 responseError_Memory  output  1  meaning the request was misaligned or out of range.
REQ-013 loadEnable  input  1  meaning write one word into the array.
REQ-014 loadAddress  input  log2(DEPTH_WORDS)  meaning the word index for the load.
REQ-015 loadData  input  32  meaning the word to load.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESPOND.
REQ-017 requestReady_Memory SHALL be 1 iff state is IDLE or RESPOND, and loadEnable=0, and flushRequest_Fetch=0.
REQ-018 A request SHALL be accepted in the cycle where requestValid_Fetch and requestReady_Memory are both 1; on acceptance the block latches the address and loads the counter with LATENCY-1.
REQ-019 Acceptance in cycle C SHALL produce responseValid_Memory=1 in exactly cycle C+LATENCY, for exactly one cycle.
REQ-020 State transitions on acceptance: if LATENCY=1, next state is RESPOND; otherwise next state is WAIT.
REQ-021 In WAIT, the counter SHALL decrement each cycle, and state SHALL go to RESPOND at the edge where counter=1.
REQ-022 When RESPOND is left with no new acceptance, next state SHALL be IDLE.
REQ-023 A new acceptance during RESPOND SHALL restart the sequence; with LATENCY=1 this gives one response per cycle.
REQ-024 responseInstruction_Memory, responseAddress_Memory and responseError_Memory SHALL be registered on entry to RESPOND and hold their values otherwise.
REQ-025 Error conditions: address[1:0]!=0, or word index (address>>2) >= DEPTH_WORDS; for either, the response SHALL carry instruction 32'h0 and error=1.
REQ-026 For a legal address, the response SHALL carry array[address>>2] and error=0.
REQ-027 flushRequest_Fetch=1 in WAIT SHALL force next state IDLE; no response is issued for the abandoned request.
REQ-028 flushRequest_Fetch=1 in RESPOND SHALL force responseValid_Memory=0 that cycle; the data outputs still update.
REQ-029 Flush and requestValid_Fetch in the same cycle: flush wins, and no acceptance occurs.
REQ-030 loadEnable SHALL write loadData to array[loadAddress] only in IDLE; in WAIT or RESPOND the load is ignored.
REQ-031 loadEnable and requestValid_Fetch in the same IDLE cycle: the load is performed and the request is not accepted.
REQ-032 A load to the index of an in-flight request cannot occur, per REQ-030.

Reset
REQ-033 When resetMachine=1 at an edge, the next state SHALL be IDLE, the counter 0, and responseValid/Instruction/Address/Error all 0.
REQ-034 Reset SHALL have priority over flush, load and acceptance.
REQ-035 Reset during WAIT or RESPOND SHALL drop the in-flight request, with no later response.
REQ-036 Array contents SHALL NOT be cleared by reset.
REQ-037 requestReady_Memory SHALL be 1 in the first cycle after reset deasserts, provided loadEnable=0 and flush=0.

Verification
REQ-038 Setup: LATENCY=2; load array[3]=32'h2002_0005, then request address 0x0C in cycle C -> ready=0 in C+1; valid=1 in C+2 with instruction 32'h2002_0005, address 0x0C, error=0.
REQ-039 Setup: LATENCY=1; requests 0x0,0x4,0x8 held valid on consecutive cycles -> three consecutive response pulses in address order, ready held 1 throughout.
REQ-040 Request address 0x6 (misaligned) and address 4*DEPTH_WORDS (out of range) -> each response has instruction 0 and error=1.
REQ-041 Setup: LATENCY=3; accept in C, flush in C+1 -> no response in C+3, state IDLE in C+2; also flush coincident with a valid request -> no acceptance.
REQ-042 Setup: LATENCY=3; reset asserted in C+1 after acceptance in C -> all outputs 0, no response ever; array data survives (re-request returns the loaded word).
REQ-043 loadEnable issued during WAIT -> array unchanged; loadEnable issued in IDLE together with valid -> word written, request not accepted (ready=0).
